// File: rtl/lcd_panel_rx.sv
// Receive side of an HD44780-style 8-bit parallel LCD bus: decodes EN/RW/RS strobes into a
// 2x16 character buffer, address counter, display flags and busy timing.
module lcd_panel_rx #(
  parameter int unsigned BUSY_CYC  = 2000,
  parameter int unsigned CLEAR_CYC = 82000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       EN,
  input  logic       RW,
  input  logic       RS,
  input  logic [7:0] data,
  output logic [7:0] data_out,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  output logic       busy,
  output logic [6:0] ac,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       two_line,
  output logic       cmd_error,
  output logic       overrun
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam logic [31:0] LP_BUSY     = BUSY_CYC;
  localparam logic [31:0] LP_CLEAR    = CLEAR_CYC;
  localparam logic [31:0] LP_CLR_WAIT = CLEAR_CYC - 32;

  logic [1:0]  r_state, w_state_d;
  logic [31:0] r_cnt, w_cnt_d;
  logic [4:0]  r_idx, w_idx_d;
  logic [6:0]  r_ac, w_ac_d;
  logic        r_inc, w_inc_d;
  logic        r_disp, w_disp_d;
  logic        r_cur, w_cur_d;
  logic        r_blink, w_blink_d;
  logic        r_two, w_two_d;
  logic        r_err, w_err;
  logic        r_ovr, w_ovr_d;
  logic        r_en_q;
  logic [7:0]  r_dout;
  logic [7:0]  r_buf [32];

  logic        w_strobe;
  logic        w_busy;
  logic        w_we;
  logic [4:0]  w_waddr;
  logic [7:0]  w_wdata;
  logic        w_slot_ok;
  logic [4:0]  w_slot;
  logic        w_addr_ok;

  // Two 40-column DDRAM lines at 0x00 and 0x40; stepping wraps across both.
  function automatic logic [6:0] f_step(input logic [6:0] a, input logic up);
    if (up) begin
      if (a == 7'h27) return 7'h40;
      if (a == 7'h67) return 7'h00;
      return a + 7'd1;
    end
    if (a == 7'h40) return 7'h27;
    if (a == 7'h00) return 7'h67;
    return a - 7'd1;
  endfunction

  assign w_strobe  = r_en_q & ~EN;
  assign w_busy    = (r_state != ST_IDLE);
  assign w_slot_ok = (r_ac[6:4] == 3'b000) || (r_ac[6:4] == 3'b100);
  assign w_slot    = {r_ac[6], r_ac[3:0]};
  assign w_addr_ok = (data[6:0] <= 7'h27) || ((data[6:0] >= 7'h40) && (data[6:0] <= 7'h67));

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_idx_d   = r_idx;
    w_ac_d    = r_ac;
    w_inc_d   = r_inc;
    w_disp_d  = r_disp;
    w_cur_d   = r_cur;
    w_blink_d = r_blink;
    w_two_d   = r_two;
    w_err     = 1'b0;
    w_ovr_d   = r_ovr;
    w_we      = 1'b0;
    w_waddr   = r_idx;
    w_wdata   = 8'h20;

    case (r_state)
      ST_CLEAR: begin
        w_we    = 1'b1;
        w_idx_d = r_idx + 5'd1;
        if (r_idx == 5'd31) begin
          w_state_d = ST_WAIT;
          w_cnt_d   = LP_CLR_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cnt <= 32'd1) w_state_d = ST_IDLE;
        else                w_cnt_d   = r_cnt - 32'd1;
      end
      default: ;
    endcase

    if (w_strobe) begin
      if (RW) begin
        w_err = RS;
      end else if (w_busy) begin
        w_ovr_d = 1'b1;
      end else begin
        w_state_d = ST_WAIT;
        w_cnt_d   = LP_BUSY;
        if (RS) begin
          if (w_slot_ok) begin
            w_we    = 1'b1;
            w_waddr = w_slot;
            w_wdata = data;
          end
          w_ac_d = f_step(r_ac, r_inc);
        end else begin
          casez (data)
            8'b1???????: begin
              if (w_addr_ok) w_ac_d = data[6:0];
              else           w_err  = 1'b1;
            end
            8'b01??????: ;
            8'b001?????: begin
              w_two_d = data[3];
              w_err   = ~data[4];
            end
            8'b0001????: begin
              if (data[3]) w_err  = 1'b1;
              else         w_ac_d = f_step(r_ac, data[2]);
            end
            8'b00001???: begin
              w_disp_d  = data[2];
              w_cur_d   = data[1];
              w_blink_d = data[0];
            end
            8'b000001??: begin
              w_inc_d = data[1];
              w_err   = data[0];
            end
            8'b0000001?: begin
              w_ac_d  = 7'h00;
              w_cnt_d = LP_CLEAR;
            end
            8'b00000001: begin
              w_state_d = ST_CLEAR;
              w_idx_d   = 5'd0;
              w_ac_d    = 7'h00;
              w_inc_d   = 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_CLEAR;
      r_cnt   <= 32'd0;
      r_idx   <= 5'd0;
      r_ac    <= 7'h00;
      r_inc   <= 1'b1;
      r_disp  <= 1'b0;
      r_cur   <= 1'b0;
      r_blink <= 1'b0;
      r_two   <= 1'b0;
      r_err   <= 1'b0;
      r_ovr   <= 1'b0;
      r_en_q  <= 1'b0;
      r_dout  <= 8'h80;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_idx   <= w_idx_d;
      r_ac    <= w_ac_d;
      r_inc   <= w_inc_d;
      r_disp  <= w_disp_d;
      r_cur   <= w_cur_d;
      r_blink <= w_blink_d;
      r_two   <= w_two_d;
      r_err   <= w_err;
      r_ovr   <= w_ovr_d;
      r_en_q  <= EN;
      r_dout  <= {w_busy, r_ac};
    end
  end

  // Buffer needs no reset: the fill sequence initialises it.
  always_ff @(posedge clk) begin
    if (w_we) r_buf[w_waddr] <= w_wdata;
  end

  assign rd_char    = r_buf[rd_addr];
  assign data_out   = r_dout;
  assign busy       = w_busy;
  assign ac         = r_ac;
  assign display_on = r_disp;
  assign cursor_on  = r_cur;
  assign blink_on   = r_blink;
  assign two_line   = r_two;
  assign cmd_error  = r_err;
  assign overrun    = r_ovr;

endmodule
